obi_wb_bridge_mw: RTL

Next-generation OBI-to-Wishbone master bridge with N parametrised address windows, per-window base translation, and offset pass-through.
- Adds OBI error responses for unmapped addresses, Wishbone bus errors and a Wishbone ack timeout.
- Sits between the core data OBI port and the Smartwave peripheral Wishbone bus (pinmux, I2C target and later blocks).

---
 rtl/obi_wb_pkg.sv | 22 ++
 rtl/obi_wb_addr_decode.sv | 51 +++++
 rtl/obi_wb_bridge_mw.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone multi-window bridge.
// Holds the bridge FSM states and the Smartwave peripheral window map.
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] D_P_MATRIX_WB_BASE = 32'h0004_6000;
  localparam logic [31:0] DRIVE_I2CT_WB_BASE = 32'h0008_6000;

  localparam logic [7:0] PINMUX_SEL = 8'h0F;
  localparam logic [7:0] I2C_SEL    = 8'h0E;

  // A single window still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_wb_addr_decode.sv
// Combinational window decoder: matches the top address bits against each
// window select and rebases the low offset bits onto that window's WB base.
module obi_wb_addr_decode
  import obi_wb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int N_WIN  = 2,
  parameter int SEL_W  = 8,
  parameter int OFFS_W = 8,
  parameter logic [N_WIN*SEL_W-1:0]  WIN_SEL  = {I2C_SEL, PINMUX_SEL},
  parameter logic [N_WIN*ADDR_W-1:0] WIN_BASE = {DRIVE_I2CT_WB_BASE, D_P_MATRIX_WB_BASE}
) (
  input  logic [ADDR_W-1:0]       i_addr,
  output logic                    o_hit,
  output logic [idx_w(N_WIN)-1:0] o_win_idx,
  output logic [ADDR_W-1:0]       o_addr
);

  localparam int IDX_W = idx_w(N_WIN);

  logic [SEL_W-1:0]  w_sel;
  logic [N_WIN-1:0]  w_hit_vec;
  logic [ADDR_W-1:0] w_offs;
  logic              w_unused_mid;

  assign w_sel        = i_addr[ADDR_W-1 -: SEL_W];
  assign w_offs       = {{(ADDR_W-OFFS_W){1'b0}}, i_addr[OFFS_W-1:0]};
  assign w_unused_mid = ^i_addr[ADDR_W-SEL_W-1:OFFS_W];

  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < N_WIN; i++) begin
      w_hit_vec[i] = (w_sel == WIN_SEL[i*SEL_W +: SEL_W]);
    end
  end

  // Walk from the highest index down so the lowest matching window wins.
  always_comb begin
    o_hit     = 1'b0;
    o_win_idx = '0;
    o_addr    = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        o_hit     = 1'b1;
        o_win_idx = IDX_W'(i);
        o_addr    = WIN_BASE[i*ADDR_W +: ADDR_W] | w_offs;
      end
    end
  end

endmodule

// File: rtl/obi_wb_bridge_mw.sv
// OBI slave to Wishbone master bridge with windowed address translation,
// OBI error responses for unmapped accesses, WB bus errors and ack timeout.
module obi_wb_bridge_mw
  import obi_wb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_WIN       = 2,
  parameter int SEL_W       = 8,
  parameter int OFFS_W      = 8,
  parameter logic [N_WIN*SEL_W-1:0]  WIN_SEL  = {I2C_SEL, PINMUX_SEL},
  parameter logic [N_WIN*ADDR_W-1:0] WIN_BASE = {DRIVE_I2CT_WB_BASE, D_P_MATRIX_WB_BASE},
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                wr_en_i,
  input  logic [DATA_W/8-1:0] byte_en_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   addr_o,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                wr_en_o,
  output logic [DATA_W/8-1:0] byte_en_o,
  output logic                stb_o,
  output logic                cyc_o,
  input  logic                ack_i,
  input  logic                err_i,
  output logic                timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_wr_en;
  logic [DATA_W/8-1:0]     r_be;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;
  logic                    r_timeout;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_dec_hit;
  logic [idx_w(N_WIN)-1:0] w_win_idx;
  logic [ADDR_W-1:0]       w_dec_addr;
  logic                    w_timeout_hit;
  logic                    w_unused_idx;

  obi_wb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .N_WIN    (N_WIN),
    .SEL_W    (SEL_W),
    .OFFS_W   (OFFS_W),
    .WIN_SEL  (WIN_SEL),
    .WIN_BASE (WIN_BASE)
  ) u_decode (
    .i_addr    (addr_i),
    .o_hit     (w_dec_hit),
    .o_win_idx (w_win_idx),
    .o_addr    (w_dec_addr)
  );

  // The window index is only informative here; translation already used it.
  assign w_unused_idx = ^w_win_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_state_nxt = w_dec_hit ? BUS : RESP;
        end
      end
      BUS: begin
        if (err_i || ack_i) begin
          w_state_nxt = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = RESP;
          w_timeout_hit = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture in IDLE, completion capture in BUS; a miss is answered
  // straight from the capture with err set and zero read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr_en   <= 1'b0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= w_timeout_hit;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_addr  <= w_dec_addr;
            r_wdata <= wdata_i;
            r_wr_en <= wr_en_i;
            r_be    <= byte_en_i;
            r_err   <= ~w_dec_hit;
            r_rdata <= '0;
            r_cnt   <= '0;
          end
        end
        BUS: begin
          if (err_i) begin
            r_err <= 1'b1;
          end else if (ack_i) begin
            r_err   <= 1'b0;
            r_rdata <= r_wr_en ? '0 : data_i;
          end else if (w_timeout_hit) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt_o     = (r_state == IDLE) && req_i;
  assign cyc_o     = (r_state == BUS);
  assign stb_o     = (r_state == BUS);
  assign rvalid_o  = (r_state == RESP);
  assign err_o     = (r_state == RESP) && r_err;
  assign rdata_o   = r_rdata;
  assign timeout_o = r_timeout;
  assign addr_o    = r_addr;
  assign data_o    = r_wdata;
  assign wr_en_o   = r_wr_en;
  assign byte_en_o = r_be;

endmodule
